bp_cfg_link_loader: RTL and testbench

Parametrised, runtime-driven successor to the static per-configuration parameter tables. It walks a table of `num_entries_p` {core, addr, data} configuration writes and issues them over a valid/ready config link to `num_core_p` cores, with credit-based flow control on write acks. In broadcast mode it replicates every entry to all cores. It sits between the boot/host interface and the per-core config bus, and raises `done_o` once every issued write has been acknowledged.

---
 rtl/bp_cfg_link_loader.sv | 112 +++++++++++
 tb/tb_bp_cfg_link_loader.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/bp_cfg_link_loader.sv
// bp_cfg_link_loader: walks a table of {core, addr, data} config writes and issues
// them over a valid/ready link with credit-based flow control on write acks.
//   clk_i, reset_n_i          : clock, async active-low reset
//   start_i, broadcast_i      : begin a pass (in IDLE/DONE), mode latched with start
//   tbl_core/addr/data_i      : flattened table, entry i in slice i
//   cfg_v/core/addr/data_o    : outgoing write, cfg_ready_i accepts it
//   cfg_ack_i                 : one write acknowledged, returns one credit
//   busy_o, done_o, err_o     : SEND/DRAIN, DONE, sticky error
module bp_cfg_link_loader #(
    parameter int num_core_p       = 1,
    parameter int num_entries_p    = 8,
    parameter int cfg_core_width_p = 8,
    parameter int cfg_addr_width_p = 16,
    parameter int cfg_data_width_p = 32,
    parameter int max_credits_p    = 4
) (
    input  logic                                      clk_i,
    input  logic                                      reset_n_i,
    input  logic                                      start_i,
    input  logic                                      broadcast_i,
    input  logic [num_entries_p*cfg_core_width_p-1:0] tbl_core_i,
    input  logic [num_entries_p*cfg_addr_width_p-1:0] tbl_addr_i,
    input  logic [num_entries_p*cfg_data_width_p-1:0] tbl_data_i,
    output logic                                      cfg_v_o,
    output logic [cfg_core_width_p-1:0]               cfg_core_o,
    output logic [cfg_addr_width_p-1:0]               cfg_addr_o,
    output logic [cfg_data_width_p-1:0]               cfg_data_o,
    input  logic                                      cfg_ready_i,
    input  logic                                      cfg_ack_i,
    output logic                                      busy_o,
    output logic                                      done_o,
    output logic                                      err_o
);
    localparam int ew = (num_entries_p > 1) ? $clog2(num_entries_p) : 1;
    localparam int cw = (num_core_p > 1) ? $clog2(num_core_p) : 1;
    localparam int ow = $clog2(max_credits_p + 1);
    localparam logic [ew-1:0] last_entry_lp = ew'(num_entries_p - 1);
    localparam logic [cw-1:0] last_core_lp  = cw'(num_core_p - 1);
    localparam logic [ow-1:0] max_out_lp    = ow'(max_credits_p);

    typedef enum logic [1:0] {IDLE, SEND, DRAIN, DONE} state_e;

    state_e                      state_q, state_d;
    logic [ew-1:0]               entry_q, entry_d;
    logic [cw-1:0]               core_q, core_d;
    logic [ow-1:0]               out_q, out_d;
    logic                        bcast_q, bcast_d;
    logic                        err_q, err_d;
    logic                        hs;
    logic                        last_wr;
    logic [cfg_core_width_p-1:0] ent_core;

    always_comb begin
        ent_core   = tbl_core_i[int'(entry_q)*cfg_core_width_p +: cfg_core_width_p];
        cfg_addr_o = tbl_addr_i[int'(entry_q)*cfg_addr_width_p +: cfg_addr_width_p];
        cfg_data_o = tbl_data_i[int'(entry_q)*cfg_data_width_p +: cfg_data_width_p];
        cfg_core_o = bcast_q ? cfg_core_width_p'(core_q) : ent_core;
        // Valid depends only on flops, never on ready or ack.
        cfg_v_o    = (state_q == SEND) && (out_q < max_out_lp);
        hs         = cfg_v_o & cfg_ready_i;
        last_wr    = (entry_q == last_entry_lp) && (!bcast_q || core_q == last_core_lp);
        out_d      = (hs && !cfg_ack_i) ? out_q + 1'b1 :
                     (!hs && cfg_ack_i && out_q != '0) ? out_q - 1'b1 : out_q;
        // Stray ack (nothing outstanding) or unicast write to a nonexistent core.
        err_d      = err_q | (cfg_ack_i && !hs && out_q == '0) |
                     (hs && !bcast_q && 32'(ent_core) >= num_core_p);
        state_d    = state_q;
        entry_d    = entry_q;
        core_d     = core_q;
        bcast_d    = bcast_q;
        if ((state_q == IDLE || state_q == DONE) && start_i) begin
            state_d = SEND;
            entry_d = '0;
            core_d  = '0;
            bcast_d = broadcast_i;
        end else if (state_q == SEND && hs) begin
            if (last_wr) begin
                state_d = DRAIN;
            end else if (!bcast_q || core_q == last_core_lp) begin
                entry_d = entry_q + 1'b1;
                core_d  = '0;
            end else begin
                core_d  = core_q + 1'b1;
            end
        end else if (state_q == DRAIN &&
                     (out_q == '0 || (out_q == ow'(1) && cfg_ack_i))) begin
            state_d = DONE;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            entry_q <= '0;
            core_q  <= '0;
            out_q   <= '0;
            bcast_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            core_q  <= core_d;
            out_q   <= out_d;
            bcast_q <= bcast_d;
            err_q   <= err_d;
        end
    end

    assign busy_o = (state_q == SEND) || (state_q == DRAIN);
    assign done_o = (state_q == DONE);
    assign err_o  = err_q;
endmodule

// File: tb/tb_bp_cfg_link_loader.sv
// tb_bp_cfg_link_loader: directed bench for bp_cfg_link_loader (4 entries, 2 cores, 2 credits).
module tb_bp_cfg_link_loader;
    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        start_i, broadcast_i;
    logic [31:0] tbl_core_i;
    logic [63:0] tbl_addr_i;
    logic [127:0] tbl_data_i;
    logic        cfg_v_o;
    logic [7:0]  cfg_core_o;
    logic [15:0] cfg_addr_o;
    logic [31:0] cfg_data_o;
    logic        cfg_ready_i, cfg_ack_i;
    logic        busy_o, done_o, err_o;

    logic [7:0]  tc [4];
    logic [15:0] ta [4];
    logic [31:0] td [4];
    logic [31:0] lg_core [16];
    logic [31:0] lg_addr [16];
    logic [31:0] lg_data [16];
    int n_chk = 0, n_fail = 0;
    int n_wr, first_hs, last_hs, done_cyc;

    bp_cfg_link_loader #(
        .num_core_p(2), .num_entries_p(4), .cfg_core_width_p(8),
        .cfg_addr_width_p(16), .cfg_data_width_p(32), .max_credits_p(2)
    ) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .start_i(start_i), .broadcast_i(broadcast_i),
        .tbl_core_i(tbl_core_i), .tbl_addr_i(tbl_addr_i), .tbl_data_i(tbl_data_i),
        .cfg_v_o(cfg_v_o), .cfg_core_o(cfg_core_o), .cfg_addr_o(cfg_addr_o),
        .cfg_data_o(cfg_data_o), .cfg_ready_i(cfg_ready_i), .cfg_ack_i(cfg_ack_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic load_tbl();
        tbl_core_i = {tc[3], tc[2], tc[1], tc[0]};
        tbl_addr_i = {ta[3], ta[2], ta[1], ta[0]};
        tbl_data_i = {td[3], td[2], td[1], td[0]};
    endtask

    // One full pass: start, drive ready from a 4-cycle pattern, ack each write one cycle later.
    task automatic run_pass(input logic bc, input logic [3:0] pat);
        logic        ph, sv;
        logic [31:0] pc, pa, pd;
        n_wr = 0; first_hs = -1; last_hs = -1; done_cyc = -1;
        ph = 1'b0; sv = 1'b0; pc = '0; pa = '0; pd = '0;
        @(posedge clk_i); #1;
        start_i = 1'b1; broadcast_i = bc; cfg_ready_i = 1'b0; cfg_ack_i = 1'b0;
        for (int c = 0; c < 60 && done_cyc < 0; c++) begin
            @(posedge clk_i); #1;
            start_i = 1'b0; cfg_ready_i = pat[c%4]; cfg_ack_i = ph;
            #1;
            if (sv) begin
                check("hold_v", 32'(cfg_v_o), 1);
                check("hold_core", 32'(cfg_core_o), pc);
                check("hold_addr", 32'(cfg_addr_o), pa);
                check("hold_data", cfg_data_o, pd);
            end
            if (done_o) done_cyc = c;
            ph = cfg_v_o & cfg_ready_i;
            sv = cfg_v_o & !cfg_ready_i;
            pc = 32'(cfg_core_o); pa = 32'(cfg_addr_o); pd = cfg_data_o;
            if (ph && n_wr < 16) begin
                lg_core[n_wr] = pc; lg_addr[n_wr] = pa; lg_data[n_wr] = pd;
                if (first_hs < 0) first_hs = c;
                last_hs = c;
                n_wr++;
            end
        end
        cfg_ready_i = 1'b0; cfg_ack_i = 1'b0;
        check("done_seen", 32'(done_cyc >= 0), 1);
    endtask

    task automatic check_writes(input logic bc, input int n);
        for (int k = 0; k < n; k++) begin
            int e;
            e = bc ? k / 2 : k;
            check($sformatf("wr%0d_core", k), lg_core[k], bc ? 32'(k % 2) : 32'(tc[e]));
            check($sformatf("wr%0d_addr", k), lg_addr[k], 32'(ta[e]));
            check($sformatf("wr%0d_data", k), lg_data[k], td[e]);
        end
    endtask

    initial begin
        int cnt;
        tc[0] = 8'd0; tc[1] = 8'd1; tc[2] = 8'd1; tc[3] = 8'd0;
        for (int i = 0; i < 4; i++) begin
            ta[i] = 16'h1000 + 16'(i * 'h11);
            td[i] = 32'hC0DE_0000 + 32'(i * 'h101);
        end
        load_tbl();
        reset_n_i = 1'b0; start_i = 1'b0; broadcast_i = 1'b0;
        cfg_ready_i = 1'b0; cfg_ack_i = 1'b0;
        #12;
        check("rst_v", 32'(cfg_v_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_done", 32'(done_o), 0);
        check("rst_err", 32'(err_o), 0);
        @(posedge clk_i); #1 reset_n_i = 1'b1;

        // Unicast, ready always high.
        run_pass(1'b0, 4'b1111);
        check("uni_n", n_wr, 4);
        check("uni_first", first_hs, 0);
        check("uni_consec", last_hs - first_hs, 3);
        check("uni_done_lat", done_cyc, last_hs + 2);
        check("uni_err", 32'(err_o), 0);
        check_writes(1'b0, 4);

        // Broadcast: every entry to both cores.
        run_pass(1'b1, 4'b1111);
        check("bc_n", n_wr, 8);
        check("bc_consec", last_hs - first_hs, 7);
        check("bc_done_lat", done_cyc, last_hs + 2);
        check("bc_err", 32'(err_o), 0);
        check_writes(1'b1, 8);

        // Backpressure: ready 1,0,0,1 repeating.
        run_pass(1'b0, 4'b1001);
        check("bp_n", n_wr, 4);
        check("bp_done_lat", done_cyc, last_hs + 2);
        check_writes(1'b0, 4);

        // Credit stall: no acks, only two writes may be outstanding.
        @(posedge clk_i); #1;
        start_i = 1'b1; broadcast_i = 1'b0;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk_i); #1;
            start_i = 1'b0; cfg_ready_i = 1'b1; cfg_ack_i = 1'b0;
            #1;
            if (cfg_v_o && cfg_ready_i) cnt++;
        end
        check("stall_hs", cnt, 2);
        check("stall_v", 32'(cfg_v_o), 0);
        check("stall_busy", 32'(busy_o), 1);
        @(posedge clk_i); #1 cfg_ack_i = 1'b1;
        #1 check("ack_not_comb", 32'(cfg_v_o), 0);
        @(posedge clk_i); #1 cfg_ack_i = 1'b0;
        #1 check("ack_reissue_v", 32'(cfg_v_o), 1);
        check("ack_reissue_addr", 32'(cfg_addr_o), 32'(ta[2]));
        @(posedge clk_i); #2;
        check("restall_v", 32'(cfg_v_o), 0);

        // Reset mid-pass aborts at once.
        reset_n_i = 1'b0;
        #1;
        check("midrst_v", 32'(cfg_v_o), 0);
        check("midrst_busy", 32'(busy_o), 0);
        check("midrst_err", 32'(err_o), 0);
        @(posedge clk_i); #1 reset_n_i = 1'b1;
        run_pass(1'b0, 4'b1111);
        check("restart_n", n_wr, 4);
        check("restart_addr0", lg_addr[0], 32'(ta[0]));
        check("restart_err", 32'(err_o), 0);

        // Stray ack in IDLE, then an out-of-range core id.
        reset_n_i = 1'b0;
        @(posedge clk_i); #1 reset_n_i = 1'b1;
        check("idle_err0", 32'(err_o), 0);
        cfg_ack_i = 1'b1;
        @(posedge clk_i); #1 cfg_ack_i = 1'b0;
        #1 check("stray_ack_err", 32'(err_o), 1);
        check("stray_ack_done", 32'(done_o), 0);
        tc[2] = 8'd5;
        load_tbl();
        run_pass(1'b0, 4'b1111);
        check("badcore_n", n_wr, 4);
        check("badcore_core", lg_core[2], 5);
        check("badcore_done_lat", done_cyc, last_hs + 2);
        check("err_sticky", 32'(err_o), 1);
        reset_n_i = 1'b0;
        #1 check("err_clr_rst", 32'(err_o), 0);
        @(posedge clk_i); #1 reset_n_i = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end
endmodule
